idma_inoc_rd_burst_sched: RTL and testbench
===========================================

# idma_inoc_rd_burst_sched

Read-command scheduler for the iDMA-iNoC read path. Takes a single (address, beat-count) request from the iDMA register file and splits it into AXI read bursts. Bursts are limited by a maximum length, an optional 4 KB boundary split and a configurable outstanding-burst limit. It drives the AR channel and tracks burst completions from the R channel, then raises a one-cycle done interrupt when every issued burst has returned.

## Interface
Parameters:
- AXI4_ADDRESS_WIDTH, 32, AR address width.
- DATA_BYTES, 32, bytes per beat; power of two.
- MAX_BURST_BEATS, 16, largest burst issued; power of two, ≤256.

Ports (all synchronous to aclk; reset asynchronous, active-high):
- aclk  in  1  clock.
- areset  in  1  asynchronous active-high reset.
- rd_req  in  1  start pulse; accepted only when cfg_ready=1.
- rd_addr  in  AXI4_ADDRESS_WIDTH  start byte address; low log2(DATA_BYTES) bits ignored (treated as 0).
- rd_num  in  32  transfer length in beats.
- rd_afifo_init  in  1  soft clear/abort.
- cfg_outstd  in  4  outstanding limit minus one (limit 1..16).
- cfg_outstd_en  in  1  1 = enforce the outstanding limit.
- cfg_cross4k_en  in  1  1 = bursts may cross 4 KB; 0 = split at 4 KB.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- araddr  out  AXI4_ADDRESS_WIDTH  burst start address.
- arlen  out  8  beats−1.
- r_burst_done  in  1  rvalid&rready&rlast.
- cfg_ready  out  1  idle; new request accepted.
- rd_done_intr  out  1  one-cycle completion pulse.
- err_unexp_done  out  1  sticky: r_burst_done received with 0 outstanding.

## Operation
- States: IDLE, CALC, ISSUE, DRAIN, DONE.
- IDLE:
  - cfg_ready=1.
  - On rd_req, latch addr/num. Go to DONE if num==0, else go to CALC.
- CALC (one cycle): register len = min(remaining, MAX_BURST_BEATS, beats_to_4k if cfg_cross4k_en==0).
  - beats_to_4k = (4096 − addr[11:0]) / DATA_BYTES; always ≥1.
- ISSUE:
  - Assert arvalid once outstanding < limit (or immediately if cfg_outstd_en=0).
  - Once asserted, arvalid, araddr and arlen stay stable until arready.
  - On handshake:
    - addr += len·DATA_BYTES, with address-width wrap, no error.
    - remaining −= len.
    - outstanding += 1.
    - Go to CALC if remaining≠0, else go to DRAIN.
- DRAIN: wait until outstanding==0, then go to DONE.
- DONE: rd_done_intr=1 for one cycle, then go to IDLE.
- Outstanding counter: 5 bits.
  - Issue and r_burst_done in the same cycle → net unchanged.
  - r_burst_done with counter 0 → counter stays 0 and err_unexp_done is set; cleared only by reset or rd_afifo_init.
- rd_req while busy: ignored, no side effects.
- rd_afifo_init:
  - In any state except ISSUE with arvalid=1: go to IDLE immediately and clear remaining, outstanding and err; no done pulse.
  - In ISSUE with arvalid=1: hold arvalid until the handshake, then abort as above. The abort is recorded internally, so a one-cycle init pulse suffices.
- Cfg inputs are sampled every CALC/ISSUE cycle; software changes them only while idle.

## Timing
- Reset values: arvalid=0, araddr=0, arlen=0, cfg_ready=1, rd_done_intr=0, err_unexp_done=0, state=IDLE.
- rd_req at cycle 0 → CALC at cycle 1 → arvalid at cycle 2 at the earliest.
- Back-to-back bursts: handshake at cycle N → next arvalid at N+2 (one CALC bubble).
- num==0: rd_done_intr at cycle 1 after rd_req, cfg_ready back at cycle 2.
- Last r_burst_done at cycle M (state DRAIN) → counter 0 at M+1 → DONE / rd_done_intr at M+2 → IDLE at M+3.
- All outputs are registered; no combinational path from arready to arvalid.

## Configuration
- IDMA_INOC_RD_PERF_CNT_EN defined: adds outputs perf_burst_cnt[15:0] and perf_stall_cnt[15:0].
  - perf_burst_cnt counts AR handshakes.
  - perf_stall_cnt counts ISSUE cycles with arvalid held low by the outstanding limit.
  - Both clear on rd_req acceptance and saturate at 0xFFFF.
- Undefined: neither port nor the counters exist; behaviour is otherwise identical.

## Structure
- Shared package idma_inoc_pkg holds:
  - the state enum idma_rd_sched_state_e;
  - 4K_BYTES=4096;
  - the outstanding-counter width constant.
- Sub-module idma_inoc_rd_burst_calc: combinational len computation (min of remaining / MAX_BURST_BEATS / beats_to_4k); its output is registered in CALC.

## Test plan
Default parameters (32-byte beats, 16-beat maximum) unless stated.
- 4K split: addr=0x0FC0, num=40, cross4k_en=0 → bursts at 0x0FC0/0x1000/0x1200/0x1400 with arlen 1/15/15/5; one rd_done_intr after the 4th completion.
- Crossing allowed: same request with cross4k_en=1 → bursts 0x0FC0/0x11C0/0x13C0 with arlen 15/15/7.
- Outstanding limit: cfg_outstd=1, outstd_en=1, num=64, arready=1, r_burst_done withheld → exactly 2 AR handshakes. One r_burst_done → 3rd issues 2 cycles later.
- Zero length and busy request: rd_req with num=0 → no arvalid, rd_done_intr at cycle 1. rd_req during an active transfer → ignored, burst sequence unchanged.
- Abort: rd_afifo_init while arvalid=1, arready=0 for 3 cycles → arvalid held until arready, then IDLE, cfg_ready=1, no rd_done_intr.
- Spurious completion / reset: r_burst_done in IDLE → err_unexp_done=1, sticky until init. areset asserted mid-transfer → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/idma_inoc_pkg.sv
// Shared types and constants for the iDMA-iNoC read-command path.
package idma_inoc_pkg;

  localparam int unsigned IDMA_4K_BYTES = 4096;
  localparam int unsigned OUTSTD_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } idma_rd_sched_state_e;

endpackage

// File: rtl/idma_inoc_rd_burst_calc.sv
// Burst length = min(remaining beats, MAX_BURST_BEATS, beats left before the
// next 4 KB page when page crossing is disallowed). Purely combinational.
module idma_inoc_rd_burst_calc
  import idma_inoc_pkg::*;
#(
  parameter int DATA_BYTES      = 32,
  parameter int MAX_BURST_BEATS = 16
) (
  input  logic [31:0] i_remaining,
  input  logic [11:0] i_addr_lo,
  input  logic        i_cross4k_en,
  output logic [8:0]  o_len
);

  localparam int OFF_W = $clog2(DATA_BYTES);

  logic [12:0] w_bytes_to_4k;
  logic [12:0] w_beats_to_4k;
  logic [8:0]  w_len;

  // Address is beat aligned, so the page remainder is always at least one beat.
  assign w_bytes_to_4k = 13'(IDMA_4K_BYTES) - {1'b0, i_addr_lo};
  assign w_beats_to_4k = w_bytes_to_4k >> OFF_W;

  // Successive min against each limit.
  always_comb begin
    w_len = 9'(MAX_BURST_BEATS);
    if (i_remaining < 32'(MAX_BURST_BEATS)) w_len = i_remaining[8:0];
    if (!i_cross4k_en && ({4'd0, w_len} > w_beats_to_4k)) w_len = w_beats_to_4k[8:0];
  end

  assign o_len = w_len;

endmodule

// File: rtl/idma_inoc_rd_burst_sched.sv
// Read-command scheduler: splits one (addr, beats) request into AXI AR bursts,
// tracks outstanding bursts and pulses rd_done_intr when all have returned.
// Optional feature macro: IDMA_INOC_RD_PERF_CNT_EN adds burst/stall counters.
module idma_inoc_rd_burst_sched
  import idma_inoc_pkg::*;
#(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int DATA_BYTES         = 32,
  parameter int MAX_BURST_BEATS    = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          rd_req,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [31:0]                   rd_num,
  input  logic                          rd_afifo_init,
  input  logic [3:0]                    cfg_outstd,
  input  logic                          cfg_outstd_en,
  input  logic                          cfg_cross4k_en,
  output logic                          arvalid,
  input  logic                          arready,
  output logic [AXI4_ADDRESS_WIDTH-1:0] araddr,
  output logic [7:0]                    arlen,
  input  logic                          r_burst_done,
  output logic                          cfg_ready,
  output logic                          rd_done_intr,
  output logic                          err_unexp_done
`ifdef IDMA_INOC_RD_PERF_CNT_EN
  ,
  output logic [15:0]                   perf_burst_cnt,
  output logic [15:0]                   perf_stall_cnt
`endif
);

  localparam int AW    = AXI4_ADDRESS_WIDTH;
  localparam int OFF_W = $clog2(DATA_BYTES);
  localparam logic [AW-1:0] ADDR_MASK = ~AW'(DATA_BYTES - 1);

  idma_rd_sched_state_e r_state, w_nstate;

  logic [AW-1:0]       r_addr;
  logic [31:0]         r_rem;
  logic [8:0]          r_len;
  logic [8:0]          w_len;
  logic [OUTSTD_W-1:0] r_outstd;
  logic                r_err;
  logic                r_abort_pend;
  logic                r_arvalid, w_arvalid_nxt;
  logic [AW-1:0]       r_araddr,  w_araddr_nxt;
  logic [7:0]          r_arlen,   w_arlen_nxt;
  logic                r_ready,   w_ready_nxt;
  logic                r_done,    w_done_nxt;

  logic          w_hs, w_accept, w_abort_now, w_clear, w_can_issue, w_last;
  logic [AW-1:0] w_step;

  idma_inoc_rd_burst_calc #(
    .DATA_BYTES      (DATA_BYTES),
    .MAX_BURST_BEATS (MAX_BURST_BEATS)
  ) u_calc (
    .i_remaining  (r_rem),
    .i_addr_lo    (r_addr[11:0]),
    .i_cross4k_en (cfg_cross4k_en),
    .o_len        (w_len)
  );

  assign w_hs        = r_arvalid && arready;
  assign w_accept    = (r_state == ST_IDLE) && rd_req && !rd_afifo_init;
  // An init that lands while AR is presented must wait for the handshake.
  assign w_abort_now = rd_afifo_init && !((r_state == ST_ISSUE) && r_arvalid);
  assign w_clear     = w_abort_now || (w_hs && (rd_afifo_init || r_abort_pend));
  assign w_can_issue = !cfg_outstd_en || (r_outstd <= {1'b0, cfg_outstd});
  assign w_last      = (r_rem == {23'd0, r_len});
  assign w_step      = AW'(r_len) << OFF_W;

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_nstate;
  end

  // Next-state logic; any effective abort returns to IDLE.
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_nstate = (rd_num == 32'd0) ? ST_DONE : ST_CALC;
      ST_CALC:  w_nstate = ST_ISSUE;
      ST_ISSUE: if (w_hs) w_nstate = w_last ? ST_DRAIN : ST_CALC;
      ST_DRAIN: if (r_outstd == '0) w_nstate = ST_DONE;
      ST_DONE:  w_nstate = ST_IDLE;
      default:  w_nstate = ST_IDLE;
    endcase
    if (w_clear) w_nstate = ST_IDLE;
  end

  // Output logic: next values for the registered AR / status outputs.
  always_comb begin
    w_arvalid_nxt = r_arvalid;
    w_araddr_nxt  = r_araddr;
    w_arlen_nxt   = r_arlen;
    if (w_hs)
      w_arvalid_nxt = 1'b0;
    else if (!w_clear && w_can_issue &&
             ((r_state == ST_CALC) || ((r_state == ST_ISSUE) && !r_arvalid)))
      w_arvalid_nxt = 1'b1;
    if (r_state == ST_CALC) begin
      w_araddr_nxt = r_addr;
      w_arlen_nxt  = 8'(w_len - 9'd1);
    end
    w_ready_nxt = (w_nstate == ST_IDLE);
    w_done_nxt  = (w_nstate == ST_DONE);
  end

  // Output registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_arvalid <= w_arvalid_nxt;
      r_araddr  <= w_araddr_nxt;
      r_arlen   <= w_arlen_nxt;
      r_ready   <= w_ready_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Request datapath: latch, per-burst length, advance on handshake.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_addr       <= '0;
      r_rem        <= '0;
      r_len        <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= rd_addr & ADDR_MASK;
        r_rem  <= rd_num;
      end else if (w_clear) begin
        r_rem <= '0;
      end else if (w_hs) begin
        r_addr <= r_addr + w_step;
        r_rem  <= r_rem - {23'd0, r_len};
      end
      if (r_state == ST_CALC) r_len <= w_len;
      if (w_hs || w_abort_now) r_abort_pend <= 1'b0;
      else if (rd_afifo_init)  r_abort_pend <= 1'b1;
    end
  end

  // Outstanding-burst counter and sticky unexpected-completion flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_outstd <= '0;
      r_err    <= 1'b0;
    end else if (w_clear) begin
      r_outstd <= '0;
      r_err    <= 1'b0;
    end else if (w_hs && !r_burst_done) begin
      r_outstd <= r_outstd + 1'b1;
    end else if (r_burst_done && !w_hs) begin
      if (r_outstd == '0) r_err    <= 1'b1;
      else                r_outstd <= r_outstd - 1'b1;
    end
  end

  assign arvalid        = r_arvalid;
  assign araddr         = r_araddr;
  assign arlen          = r_arlen;
  assign cfg_ready      = r_ready;
  assign rd_done_intr   = r_done;
  assign err_unexp_done = r_err;

`ifdef IDMA_INOC_RD_PERF_CNT_EN
  logic [15:0] r_perf_burst, r_perf_stall;

  // Saturating burst / limit-stall counters, cleared when a request is taken.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_perf_burst <= '0;
      r_perf_stall <= '0;
    end else if (w_accept) begin
      r_perf_burst <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_hs && (r_perf_burst != 16'hFFFF)) r_perf_burst <= r_perf_burst + 1'b1;
      if ((r_state == ST_ISSUE) && !r_arvalid && !w_can_issue && (r_perf_stall != 16'hFFFF))
        r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign perf_burst_cnt = r_perf_burst;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_idma_inoc_rd_burst_sched.sv
// Self-checking bench for idma_inoc_rd_burst_sched: a burst-plan model plus a
// per-cycle compare process, and directed scenarios with literal timing checks.
module tb_idma_inoc_rd_burst_sched;

  localparam int DB = 32;
  localparam int MB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] rd_num = '0;
  logic        rd_afifo_init = 1'b0;
  logic [3:0]  cfg_outstd = 4'd0;
  logic        cfg_outstd_en = 1'b0;
  logic        cfg_cross4k_en = 1'b0;
  logic        arvalid;
  logic        arready = 1'b1;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        r_burst_done;
  logic        cfg_ready;
  logic        rd_done_intr;
  logic        err_unexp_done;
`ifdef IDMA_INOC_RD_PERF_CNT_EN
  logic [15:0] perf_burst_cnt, perf_stall_cnt;
`endif

  logic r_auto = 1'b0;
  logic r_man  = 1'b0;
  logic resp_en = 1'b0;
  assign r_burst_done = r_auto | r_man;

  always #5 clk = ~clk;

  idma_inoc_rd_burst_sched dut (
    .aclk           (clk),
    .areset         (rst),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_num         (rd_num),
    .rd_afifo_init  (rd_afifo_init),
    .cfg_outstd     (cfg_outstd),
    .cfg_outstd_en  (cfg_outstd_en),
    .cfg_cross4k_en (cfg_cross4k_en),
    .arvalid        (arvalid),
    .arready        (arready),
    .araddr         (araddr),
    .arlen          (arlen),
    .r_burst_done   (r_burst_done),
    .cfg_ready      (cfg_ready),
    .rd_done_intr   (rd_done_intr),
    .err_unexp_done (err_unexp_done)
`ifdef IDMA_INOC_RD_PERF_CNT_EN
    ,
    .perf_burst_cnt (perf_burst_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;
  typedef burst_t burst_q_t[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Burst plan straight from the splitting rules.
  function automatic burst_q_t plan(input logic [31:0] a0, input logic [31:0] n0, input logic x);
    burst_q_t    q;
    logic [31:0] a, n, l, t;
    a = a0 & ~32'(DB - 1);
    n = n0;
    while (n != 0) begin
      l = 32'(MB);
      if (n < l) l = n;
      if (!x) begin
        t = (32'd4096 - {20'd0, a[11:0]}) / 32'(DB);
        if (t < l) l = t;
      end
      q.push_back('{addr: a, len: 8'(l - 1)});
      a = a + l * 32'(DB);
      n = n - l;
    end
    return q;
  endfunction

  // ---------------- model + compare process ----------------
  burst_q_t exp_q;
  int       m_outstd = 0;
  bit       m_err = 0, m_active = 0, m_pend = 0;
  int       hs_total = 0, done_cnt = 0;
  logic        prev_vld = 0, prev_rdy = 0;
  logic [31:0] prev_addr = 0;
  logic [7:0]  prev_len = 0;

  always @(negedge clk) begin
    burst_t b;
    logic   hs, bd;
    if (rst) begin
      exp_q.delete();
      m_outstd = 0; m_err = 0; m_active = 0; m_pend = 0;
      prev_vld = 0;
    end else begin
      hs = arvalid && arready;
      bd = r_burst_done;
      chk("err_unexp_done", err_unexp_done, m_err);
      if (prev_vld && !prev_rdy) begin
        chk("ar_hold_valid", arvalid, 1);
        chk("ar_hold_addr", araddr, prev_addr);
        chk("ar_hold_len", arlen, prev_len);
      end
      if (rd_done_intr) begin
        chk("done_conditions", {m_active, exp_q.size() == 0, m_outstd == 0}, 3'b111);
        m_active = 0;
        done_cnt++;
      end
      if (hs) begin
        hs_total++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ar_unexpected_burst: got araddr 0x%0h, expected no burst", araddr);
        end else begin
          b = exp_q.pop_front();
          chk("ar_addr", araddr, b.addr);
          chk("ar_len", arlen, b.len);
        end
        if (cfg_outstd_en) chk("outstd_limit", m_outstd <= int'(cfg_outstd), 1);
      end
      if (hs && !bd) m_outstd++;
      else if (bd && !hs) begin
        if (m_outstd == 0) m_err = 1;
        else m_outstd--;
      end
      if ((rd_afifo_init && !arvalid) || (hs && (rd_afifo_init || m_pend))) begin
        exp_q.delete();
        m_outstd = 0; m_err = 0; m_active = 0; m_pend = 0;
      end else if (rd_afifo_init) m_pend = 1;
      if (rd_req && cfg_ready && !rd_afifo_init) begin
        exp_q = plan(rd_addr, rd_num, cfg_cross4k_en);
        m_active = 1;
      end
      prev_vld = arvalid; prev_rdy = arready; prev_addr = araddr; prev_len = arlen;
    end
  end

  // R-channel responder: returns one burst per cycle while any is outstanding.
  always @(posedge clk) begin
    #1;
    r_auto = resp_en && !rst && (m_outstd > 0);
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int d0, input string nm);
    int k = 0;
    while (done_cnt == d0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == d0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: rd_done_intr count %0d, required %0d within 500 cycles", nm, done_cnt, d0 + 1);
    end
  endtask

  task automatic wait_arvalid(input string nm);
    int k = 0;
    @(negedge clk);
    while (!arvalid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!arvalid) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: arvalid 0, required 1 within 50 cycles", nm);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    burst_q_t    p;
    logic [31:0] ea[4];
    logic [7:0]  el[4];
    int d0, h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_done_intr", rd_done_intr, 0);
    chk("rst_err", err_unexp_done, 0);
    tick(); rst = 1'b0;
    tick(); tick();

    // Pin the model with hand-computed plans
    p = plan(32'h0FC0, 32'd40, 1'b0);
    ea = '{32'h0FC0, 32'h1000, 32'h1200, 32'h1400};
    el = '{8'd1, 8'd15, 8'd15, 8'd5};
    chk("plan_4k_count", p.size(), 4);
    if (p.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("plan_4k_addr", p[i].addr, ea[i]);
        chk("plan_4k_len", p[i].len, el[i]);
      end
    p = plan(32'h0FC0, 32'd40, 1'b1);
    ea = '{32'h0FC0, 32'h11C0, 32'h13C0, 32'h0};
    el = '{8'd15, 8'd15, 8'd7, 8'd0};
    chk("plan_x4k_count", p.size(), 3);
    if (p.size() == 3)
      for (int i = 0; i < 3; i++) begin
        chk("plan_x4k_addr", p[i].addr, ea[i]);
        chk("plan_x4k_len", p[i].len, el[i]);
      end

    // 4K split with literal timing
    cfg_cross4k_en = 0; arready = 1; resp_en = 1;
    d0 = done_cnt; h0 = hs_total;
    rd_req = 1; rd_addr = 32'h0FC0; rd_num = 40;
    @(negedge clk);
    tick(); rd_req = 0;
    @(negedge clk);
    chk("t1_c1_arvalid", arvalid, 0);
    chk("t1_c1_cfg_ready", cfg_ready, 0);
    tick(); @(negedge clk);
    chk("t1_c2_arvalid", arvalid, 1);
    chk("t1_c2_araddr", araddr, 32'h0FC0);
    chk("t1_c2_arlen", arlen, 1);
    tick(); @(negedge clk);
    chk("t1_c3_bubble", arvalid, 0);
    tick(); @(negedge clk);
    chk("t1_c4_arvalid", arvalid, 1);
    chk("t1_c4_araddr", araddr, 32'h1000);
    chk("t1_c4_arlen", arlen, 15);
    wait_done(d0, "t1_done");
    @(negedge clk);
    chk("t1_after_ready", cfg_ready, 1);
    chk("t1_after_intr", rd_done_intr, 0);
    repeat (5) tick();
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_bursts", hs_total - h0, 4);

    // Crossing allowed
    tick(); cfg_cross4k_en = 1;
    d0 = done_cnt; h0 = hs_total;
    rd_req = 1; rd_addr = 32'h0FC0; rd_num = 40;
    tick(); rd_req = 0;
    wait_done(d0, "t2_done");
    repeat (3) tick();
    chk("t2_bursts", hs_total - h0, 3);
    cfg_cross4k_en = 0;

    // Outstanding limit of 2
    tick(); cfg_outstd = 1; cfg_outstd_en = 1; resp_en = 0;
    d0 = done_cnt; h0 = hs_total;
    rd_req = 1; rd_addr = 32'h0; rd_num = 64;
    tick(); rd_req = 0;
    repeat (20) tick();
    @(negedge clk);
    chk("t3_limited_bursts", hs_total - h0, 2);
    chk("t3_blocked_arvalid", arvalid, 0);
    tick(); r_man = 1;
    @(negedge clk);
    tick(); r_man = 0;
    @(negedge clk);
    chk("t3_k1_arvalid", arvalid, 0);
    tick(); @(negedge clk);
    chk("t3_k2_arvalid", arvalid, 1);
    tick(); @(negedge clk);
    chk("t3_third_burst", hs_total - h0, 3);
    resp_en = 1;
    wait_done(d0, "t3_done");
    repeat (3) tick();
    chk("t3_all_bursts", hs_total - h0, 4);
    cfg_outstd_en = 0;

    // Zero length
    tick(); d0 = done_cnt; h0 = hs_total;
    rd_req = 1; rd_addr = 32'h40; rd_num = 0;
    @(negedge clk);
    tick(); rd_req = 0;
    @(negedge clk);
    chk("t4_c1_intr", rd_done_intr, 1);
    chk("t4_c1_arvalid", arvalid, 0);
    tick(); @(negedge clk);
    chk("t4_c2_ready", cfg_ready, 1);
    chk("t4_c2_intr", rd_done_intr, 0);
    chk("t4_done_count", done_cnt - d0, 1);
    chk("t4_no_bursts", hs_total - h0, 0);

    // Request while busy is ignored
    tick(); d0 = done_cnt; h0 = hs_total;
    rd_req = 1; rd_addr = 32'h2000; rd_num = 20;
    tick(); rd_req = 0;
    tick(); tick();
    rd_req = 1; rd_addr = 32'h5000; rd_num = 5;
    tick(); rd_req = 0;
    wait_done(d0, "t5_done");
    repeat (3) tick();
    chk("t5_bursts", hs_total - h0, 2);
    chk("t5_done_count", done_cnt - d0, 1);

    // Abort while AR is presented
    tick(); resp_en = 0; arready = 0; d0 = done_cnt;
    rd_req = 1; rd_addr = 32'h100; rd_num = 8;
    tick(); rd_req = 0;
    wait_arvalid("t6_arvalid");
    tick(); rd_afifo_init = 1;
    @(negedge clk); chk("t6_hold0", arvalid, 1);
    tick(); rd_afifo_init = 0;
    @(negedge clk); chk("t6_hold1", arvalid, 1);
    tick(); @(negedge clk); chk("t6_hold2", arvalid, 1);
    tick(); arready = 1;
    @(negedge clk);
    chk("t6_hs_arvalid", arvalid, 1);
    chk("t6_hs_ready", cfg_ready, 0);
    tick(); arready = 0;
    @(negedge clk);
    chk("t6_post_arvalid", arvalid, 0);
    chk("t6_post_ready", cfg_ready, 1);
    repeat (5) tick();
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_err", err_unexp_done, 0);
    arready = 1;

    // Spurious completion, sticky until init
    tick(); r_man = 1;
    @(negedge clk);
    tick(); r_man = 0;
    @(negedge clk); chk("t7_err_set", err_unexp_done, 1);
    repeat (3) tick();
    @(negedge clk); chk("t7_err_sticky", err_unexp_done, 1);
    tick(); rd_afifo_init = 1;
    @(negedge clk);
    tick(); rd_afifo_init = 0;
    @(negedge clk); chk("t7_err_clr", err_unexp_done, 0);

    // Asynchronous reset mid-transfer
    tick(); arready = 0;
    rd_req = 1; rd_addr = 32'h3000; rd_num = 64;
    tick(); rd_req = 0;
    wait_arvalid("t8_arvalid");
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("t8_arvalid", arvalid, 0);
    chk("t8_araddr", araddr, 0);
    chk("t8_arlen", arlen, 0);
    chk("t8_cfg_ready", cfg_ready, 1);
    chk("t8_intr", rd_done_intr, 0);
    chk("t8_err", err_unexp_done, 0);
    tick(); tick(); rst = 0; arready = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("t8_idle_ready", cfg_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
